oldland_timer: RTL

OLDLAND_TIMER -- requirements
Module: oldland_timer

---
 rtl/oldland_timer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/oldland_timer.sv
// Memory-mapped countdown timer with an 8-bit prescaler, one-shot/periodic modes
// and a level interrupt, attached to the single-cycle-ack CPU data bus.
module oldland_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_bytesel,
   input  logic        d_wr_en,
   input  logic [31:0] d_wr_val,
   input  logic        d_access,
   output logic [31:0] d_data,
   output logic        d_ack,
   output logic        d_error,
   output logic        irq
);

   // Bus handshake: the CPU holds d_access until it sees d_ack or d_error. A selected
   // access seen in IDLE completes on the following cycle (RESP) with exactly one
   // strobe; d_access is ignored during RESP, so accesses complete at most every
   // second cycle.
   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
   state_t state, state_nxt;

   logic [31:0] count, count_nxt;
   logic [31:0] reload, reload_nxt;
   logic        enable, enable_nxt;
   logic        periodic, periodic_nxt;
   logic        irq_en, irq_en_nxt;
   logic [7:0]  prescale, prescale_nxt;
   logic        expired, expired_nxt;
   logic [7:0]  presc, presc_nxt;

   logic [31:0] rd_val;
   logic [31:0] d_data_nxt;
   logic        d_ack_nxt, d_error_nxt, irq_nxt;

   logic        selected, start, full_word, bad_access;
   logic        reload_wr, control_wr, status_wr;
   logic        tick, expire;
   logic [1:0]  reg_idx;
   logic        addr_unused;

   assign addr_unused = ^d_addr[1:0];
   assign selected    = d_access && (d_addr[31:4] == BASE_ADDR[31:4]);
   assign reg_idx     = d_addr[3:2];
   assign full_word   = (d_bytesel == 4'b1111);
   assign start       = (state == IDLE) && selected;
   assign bad_access  = start && (!full_word || (d_wr_en && reg_idx == 2'd0));
   assign reload_wr   = start && full_word && d_wr_en && (reg_idx == 2'd1);
   assign control_wr  = start && full_word && d_wr_en && (reg_idx == 2'd2);
   assign status_wr   = start && full_word && d_wr_en && (reg_idx == 2'd3);
   assign tick        = enable && (presc == prescale);
   assign expire      = tick && (count == 32'd0);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (selected) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_val = 32'd0;
      case (reg_idx)
         2'd0: rd_val = count;
         2'd1: rd_val = reload;
         2'd2: rd_val = {16'd0, prescale, 5'd0, irq_en, periodic, enable};
         2'd3: rd_val = {31'd0, expired};
         default: rd_val = 32'd0;
      endcase
   end

   always_comb begin
      count_nxt    = count;
      reload_nxt   = reload;
      enable_nxt   = enable;
      periodic_nxt = periodic;
      irq_en_nxt   = irq_en;
      prescale_nxt = prescale;

      if (tick) begin
         if (count != 32'd0)
            count_nxt = count - 32'd1;
         else if (periodic)
            count_nxt = reload;
         else
            enable_nxt = 1'b0;
      end

      if (reload_wr)
         reload_nxt = d_wr_val;

      // A CONTROL write lands after the timer update so the written bits win.
      if (control_wr) begin
         enable_nxt   = d_wr_val[0];
         periodic_nxt = d_wr_val[1];
         irq_en_nxt   = d_wr_val[2];
         prescale_nxt = d_wr_val[15:8];
         if (!enable && d_wr_val[0])
            count_nxt = reload;
      end

      expired_nxt = expire || (expired && !(status_wr && d_wr_val[0]));

      if (!enable || control_wr || tick)
         presc_nxt = 8'd0;
      else
         presc_nxt = presc + 8'd1;

      irq_nxt     = expired_nxt && irq_en_nxt;
      d_ack_nxt   = start && !bad_access;
      d_error_nxt = bad_access;
      d_data_nxt  = (start && !bad_access && !d_wr_en) ? rd_val : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= 32'd0;
         reload   <= 32'd0;
         enable   <= 1'b0;
         periodic <= 1'b0;
         irq_en   <= 1'b0;
         prescale <= 8'd0;
         expired  <= 1'b0;
         presc    <= 8'd0;
         d_ack    <= 1'b0;
         d_error  <= 1'b0;
         d_data   <= 32'd0;
         irq      <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         reload   <= reload_nxt;
         enable   <= enable_nxt;
         periodic <= periodic_nxt;
         irq_en   <= irq_en_nxt;
         prescale <= prescale_nxt;
         expired  <= expired_nxt;
         presc    <= presc_nxt;
         d_ack    <= d_ack_nxt;
         d_error  <= d_error_nxt;
         d_data   <= d_data_nxt;
         irq      <= irq_nxt;
      end
   end

endmodule
